// File: rtl/alu_md_ctrl.sv
// rtl/alu_md_ctrl.sv - EX-stage ALU control decode with iterative multiply/divide sequencer
module alu_md_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MD_ENABLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        alu_control,
  output logic              md_busy,
  output logic              md_stall,
  output logic              md_done,
  output logic              mf_valid,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam bit MD_ON = (MD_ENABLE != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] w_hi, w_lo, b_reg, a_raw;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              is_div_r, neg_lo, neg_hi, div_zero;

  // mult/multu/div/divu share funct[5:2]=0110; funct[1] selects divide, funct[0] unsigned
  logic is_md, is_mf, is_rtype, start;
  assign is_rtype = (alu_op == 2'b10);
  assign is_md    = MD_ON && (funct[5:2] == 4'b0110);
  assign is_mf    = MD_ON && ((funct == 6'b010000) || (funct == 6'b010010));
  assign start    = valid && is_rtype && is_md && !flush && (state == S_IDLE);

  assign md_busy  = MD_ON && (state != S_IDLE);
  assign md_done  = MD_ON && (state == S_FIN);
  assign md_stall = valid && is_rtype && (is_md || is_mf) && md_busy;
  assign mf_valid = valid && is_mf && !md_busy;
  assign mf_data  = (funct == 6'b010000) ? hi_r : lo_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  // ALU operation select from main-control alu_op and funct/opcode bits
  always_comb begin
    alu_control = 4'b0000;
    case (alu_op)
      2'b00: alu_control = 4'b0010;
      2'b01: alu_control = 4'b0110;
      2'b10: begin
        if (is_md || is_mf) begin
          alu_control = 4'b1111;
        end else begin
          case (funct)
            6'b100000: alu_control = 4'b0010;
            6'b100010: alu_control = 4'b0110;
            6'b100100: alu_control = 4'b0000;
            6'b100101: alu_control = 4'b0001;
            6'b100110: alu_control = 4'b0011;
            6'b100111: alu_control = 4'b1100;
            6'b101010: alu_control = 4'b0111;
            default:   alu_control = 4'b0000;
          endcase
        end
      end
      default: begin
        case (funct[3:0])
          4'b1100: alu_control = 4'b0000;
          4'b1101: alu_control = 4'b0001;
          4'b1110: alu_control = 4'b0011;
          4'b1010: alu_control = 4'b0111;
          default: alu_control = 4'b0000;
        endcase
      end
    endcase
  end

  // Operand magnitudes taken at start; signed ops work on absolute values
  logic              op_signed;
  logic [DATA_W-1:0] a_abs, b_abs;
  assign op_signed = !funct[0];
  assign a_abs     = (op_signed && op_a[DATA_W-1]) ? -op_a : op_a;
  assign b_abs     = (op_signed && op_b[DATA_W-1]) ? -op_b : op_b;

  // Radix-2 step: multiply adds b_reg into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_reg} : {(DATA_W+1){1'b0}});
    div_shift = {w_hi, w_lo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ge    = !div_diff[DATA_W];
    if (is_div_r) begin
      step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      step_lo = {w_lo[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], w_lo[DATA_W-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIN
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fin_hi, fin_lo;
  always_comb begin
    prod_fix = neg_lo ? -{w_hi, w_lo} : {w_hi, w_lo};
    if (!is_div_r) begin
      fin_hi = prod_fix[2*DATA_W-1:DATA_W];
      fin_lo = prod_fix[DATA_W-1:0];
    end else if (div_zero) begin
      fin_hi = a_raw;
      fin_lo = {DATA_W{1'b1}};
    end else begin
      fin_hi = neg_hi ? -w_hi : w_hi;
      fin_lo = neg_lo ? -w_lo : w_lo;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Sequencer next state: DATA_W RUN cycles then a single FIN cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (cnt == '0) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Working registers, iteration counter and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      w_hi     <= '0;
      w_lo     <= '0;
      b_reg    <= '0;
      a_raw    <= '0;
      is_div_r <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= CNT_W'(DATA_W - 1);
            w_hi     <= '0;
            w_lo     <= a_abs;
            b_reg    <= b_abs;
            a_raw    <= op_a;
            is_div_r <= funct[1];
            neg_lo   <= op_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_hi   <= op_signed && op_a[DATA_W-1];
            div_zero <= funct[1] && (op_b == '0);
          end
        end
        S_RUN: begin
          cnt  <= cnt - 1'b1;
          w_hi <= step_hi;
          w_lo <= step_lo;
        end
        S_FIN: begin
          hi_r <= fin_hi;
          lo_r <= fin_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb/tb_alu_md_ctrl.sv - directed self-checking bench for alu_md_ctrl
module tb_alu_md_ctrl;

  logic        clk = 1'b0;
  logic        reset, valid, valid8, flush;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic [7:0]  op_a8, op_b8;

  logic [3:0]  alu_control, alu_control8;
  logic        md_busy, md_stall, md_done, mf_valid;
  logic        md_busy8, md_stall8, md_done8, mf_valid8;
  logic [31:0] mf_data, hi, lo;
  logic [7:0]  mf_data8, hi8, lo8;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

  always #5 clk = ~clk;

  alu_md_ctrl #(.DATA_W(32), .MD_ENABLE(1)) u32 (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .alu_control(alu_control), .md_busy(md_busy), .md_stall(md_stall),
    .md_done(md_done), .mf_valid(mf_valid), .mf_data(mf_data),
    .hi(hi), .lo(lo)
  );

  alu_md_ctrl #(.DATA_W(8), .MD_ENABLE(1)) u8 (
    .clk(clk), .reset(reset), .valid(valid8), .flush(flush),
    .alu_op(alu_op), .funct(funct), .op_a(op_a8), .op_b(op_b8),
    .alu_control(alu_control8), .md_busy(md_busy8), .md_stall(md_stall8),
    .md_done(md_done8), .mf_valid(mf_valid8), .mf_data(mf_data8),
    .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] exp);
    alu_op = op;
    funct  = fn;
    #1;
    chk($sformatf("decode op=%b fn=%b", op, fn), alu_control, exp);
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = fn;
    op_a   = a;
    op_b   = b;
  endtask

  // Called in the start cycle; expects md_done 33 cycles later and new HI/LO after it
  task automatic finish_md(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int done_at;
    int busy_bad;
    done_at  = 0;
    busy_bad = 0;
    #1;
    chk({tag, " stall on start"}, md_stall, 1'b0);
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      tick();
      if (k == 1) begin
        valid = 1'b0;
        op_a  = 32'h1234_5678;
        op_b  = 32'h0000_0003;
      end
      if (!md_busy) busy_bad++;
      if (md_done) done_at = k;
    end
    chk({tag, " done cycle"}, done_at, 33);
    chk({tag, " busy gaps"}, busy_bad, 0);
    tick();
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " idle after"}, md_busy, 1'b0);
  endtask

  initial begin
    int stall_bad, done_cnt, done8_at;
    reset = 1'b1; valid = 1'b0; valid8 = 1'b0; flush = 1'b0;
    alu_op = 2'b00; funct = 6'b0; op_a = '0; op_b = '0; op_a8 = '0; op_b8 = '0;
    repeat (2) tick();
    chk("reset busy", md_busy, 1'b0);
    chk("reset done", md_done, 1'b0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    reset = 1'b0;

    dec(2'b00, 6'b111111, 4'b0010);
    dec(2'b01, 6'b000000, 4'b0110);
    dec(2'b10, 6'b100000, 4'b0010);
    dec(2'b10, 6'b100010, 4'b0110);
    dec(2'b10, 6'b100100, 4'b0000);
    dec(2'b10, 6'b100101, 4'b0001);
    dec(2'b10, 6'b100110, 4'b0011);
    dec(2'b10, 6'b100111, 4'b1100);
    dec(2'b10, 6'b101010, 4'b0111);
    dec(2'b10, F_MULTU, 4'b1111);
    dec(2'b10, F_DIV, 4'b1111);
    dec(2'b10, F_MFLO, 4'b1111);
    dec(2'b10, 6'b101111, 4'b0000);
    dec(2'b11, 6'b001100, 4'b0000);
    dec(2'b11, 6'b001101, 4'b0001);
    dec(2'b11, 6'b001110, 4'b0011);
    dec(2'b11, 6'b001010, 4'b0111);
    dec(2'b11, 6'b000111, 4'b0000);
    tick();

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_md("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_md("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(F_DIVU, 32'h0000_0007, 32'h0000_0000);
    finish_md("divu 7/0", 32'h0000_0007, 32'hFFFF_FFFF);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_md("div ovf", 32'h0000_0000, 32'h8000_0000);

    issue(F_MULT, 32'h0000_0003, 32'hFFFF_FFFC);
    stall_bad = 0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 1) funct = F_MFLO;
      if (md_stall !== 1'b1 || mf_valid !== 1'b0) stall_bad++;
    end
    chk("mflo stall window", stall_bad, 0);
    tick();
    chk("mflo stall released", md_stall, 1'b0);
    chk("mflo valid", mf_valid, 1'b1);
    chk("mflo data", mf_data, 32'hFFFF_FFF4);
    funct = F_MFHI;
    #1;
    chk("mfhi data", mf_data, 32'hFFFF_FFFF);
    tick();
    valid = 1'b0;

    issue(F_MULT, 32'd5, 32'd6);
    stall_bad = 0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 1) begin
        funct = F_DIV;
        op_a  = 32'd100;
        op_b  = 32'd7;
      end
      if (md_stall !== 1'b1) stall_bad++;
    end
    chk("div stalled behind mult", stall_bad, 0);
    tick();
    flush = 1'b1;
    #1;
    chk("flushed candidate no stall", md_stall, 1'b0);
    tick();
    chk("flush blocks start", md_busy, 1'b0);
    chk("mult hi kept", hi, 32'd0);
    chk("mult lo kept", lo, 32'd30);
    flush = 1'b0;
    finish_md("div after flush", 32'd2, 32'd14);

    issue(F_MULT, 32'd5, 32'd6);
    repeat (10) tick();
    valid = 1'b0;
    chk("mid-run busy", md_busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("reset abort busy", md_busy, 1'b0);
    chk("reset abort hi", hi, 32'd0);
    chk("reset abort lo", lo, 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (md_done) done_cnt++;
      tick();
    end
    chk("no done after abort", done_cnt, 0);

    valid8 = 1'b1;
    alu_op = 2'b10;
    funct  = F_MULT;
    op_a8  = 8'h80;
    op_b8  = 8'h80;
    done8_at = 0;
    for (int k = 1; k <= 15 && done8_at == 0; k++) begin
      tick();
      if (k == 1) valid8 = 1'b0;
      if (md_done8) done8_at = k;
    end
    chk("w8 done cycle", done8_at, 9);
    tick();
    chk("w8 product", {hi8, lo8}, 16'h4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
